param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit up counter: WIDTH-bit up/down counter with programmable modulus, synchronous load/clear, count enable, wrap or saturate mode, terminal-count and overflow flags.
- General-purpose timing/event counter for sequential-circuit blocks (timers, dividers, event tallies).

Parameters:
- WIDTH, 8, counter width in bits (>=2)
- MAX_VAL, 2**WIDTH-1, top count value; counting range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends
- PRESCALE, 4, enabled-cycle divide ratio, used only when PRESCALER_EN is defined (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserts immediately; deassertion is synchronised externally)
- en  input  1  count enable
- up_dn  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- clear  input  1  synchronous clear to 0; also clears ovf
- count  output  WIDTH  registered current count
- tc  output  1  combinational terminal count
- wrap  output  1  registered single-cycle pulse on a range-end event
- ovf  output  1  registered sticky overflow/underflow flag

Behaviour:
- Reset (rst=0): count=0, wrap=0, ovf=0, prescaler=0; takes effect asynchronously, independent of clk.
- Per rising edge, priority: clear > load > en. With none asserted, count holds and wrap=0.
- clear=1: count<=0, ovf<=0, wrap<=0, prescaler<=0.
- load=1: count<=min(load_val, MAX_VAL); wrap<=0; ovf unchanged; prescaler<=0.
- en=1, up_dn=1:
  - count<MAX_VAL: count<=count+1
  - count==MAX_VAL: SATURATE=0 gives count<=0; SATURATE=1 holds at MAX_VAL. Either way wrap<=1 and ovf<=1.
- en=1, up_dn=0:
  - count>0: count<=count-1
  - count==0: SATURATE=0 gives count<=MAX_VAL; SATURATE=1 holds at 0. Either way wrap<=1 and ovf<=1.
- wrap is high for exactly one cycle per range-end event. While the counter sits saturated with en=1, wrap asserts on every enabled cycle.
- tc = (up_dn && count==MAX_VAL) || (!up_dn && count==0). Purely combinational; follows up_dn in the same cycle.
- Arithmetic is WIDTH-bit unsigned. No intermediate value outside 0..MAX_VAL is ever registered.
- up_dn may change on any cycle; the new direction applies at the next enabled edge.
- Latency: count and wrap update one edge after the qualifying inputs.

Optional Feature:
- Macro: PRESCALER_EN
- Defined:
  - A ceil(log2(PRESCALE))-bit prescaler advances on each en=1 cycle.
  - The count step and all range-end logic (wrap, ovf, saturate) occur only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - clear, load and reset zero the prescaler.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; every en=1 cycle steps the counter.

Test Plan:
- Reset mid-count: WIDTH=4, count at 9, drive rst=0 between edges -> count=0, ovf=0 immediately, without waiting for a clk edge.
- Up wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, en=1, up_dn=1 from 0 for 10 cycles -> count 0..9, tc=1 at 9, then count=0, wrap=1 for one cycle, ovf=1 and stays set.
- Down saturate: SATURATE=1, MAX_VAL=9, load 2, count down 4 cycles -> 2,1,0,0,0; wrap=1 on each cycle held at 0; ovf=1.
- Priority and clamp: clear=1, load=1, en=1 together -> count=0, ovf=0. Then load=1 with load_val=15 (MAX_VAL=9) -> count=9.
- Direction change: count=5, toggle up_dn every cycle with en=1 -> count 6,5,6,5; tc tracks up_dn combinationally.
- PRESCALER_EN, PRESCALE=3, en=1 for 9 cycles from 0 -> count=3; en=0 gaps do not advance the prescaler.

Source files
------------

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter: programmable modulus, load/clear, wrap or saturate.
// Optional enabled-cycle prescaler when PRESCALER_EN is defined.
module param_updown_counter #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter bit SATURATE = 1'b0,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   logic             step;
   logic             at_end;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] load_clamp;

`ifdef PRESCALER_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);

   logic [PW-1:0] pre;

   assign step = en && (pre == PRE_LAST);

   // Prescaler advances on enabled cycles, restarts on step/clear/load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else if (clear || load) begin
         pre <= '0;
      end else if (en) begin
         pre <= step ? '0 : pre + 1'b1;
      end
   end
`else
   assign step = en;
`endif

   // Range end depends on the direction currently requested
   assign at_end = up_dn ? (count == MAX_C) : (count == '0);
   assign tc     = at_end;

   assign load_clamp = (load_val > MAX_C) ? MAX_C : load_val;

   // Next count for an enabled step, wrapping or holding at range ends
   always_comb begin
      stepped = count;
      if (up_dn) begin
         if (at_end) stepped = SATURATE ? MAX_C : '0;
         else        stepped = count + 1'b1;
      end else begin
         if (at_end) stepped = SATURATE ? '0 : MAX_C;
         else        stepped = count - 1'b1;
      end
   end

   // Count register with clear > load > step priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else if (clear) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_clamp;
         wrap  <= 1'b0;
      end else if (step) begin
         count <= stepped;
         wrap  <= at_end;
         ovf   <= ovf | at_end;
      end else begin
         wrap  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed vector bench for param_updown_counter (wrap, saturate, prescaled).
// Build with or without PRESCALER_EN.
module tb_param_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic       clear;

   logic [3:0] count_w, count_s, count_p;
   logic       tc_w, tc_s, tc_p;
   logic       wrap_w, wrap_s, wrap_p;
   logic       ovf_w, ovf_s, ovf_p;

   int n_chk;
   int n_fail;

   typedef struct packed {
      logic       clr;
      logic       ld;
      logic       en;
      logic       ud;
      logic [3:0] lv;
      logic [3:0] cw;
      logic       ww;
      logic       ow;
      logic       tw;
      logic [3:0] cs;
      logic       ws;
      logic       os;
      logic       ts;
   } vec_t;

   localparam int NV = 26;
   vec_t v [NV];

   param_updown_counter #(
      .WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1)
   ) dut_w (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .clear(clear),
      .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
   );

   param_updown_counter #(
      .WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1)
   ) dut_s (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .clear(clear),
      .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
   );

   param_updown_counter #(
      .WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(3)
   ) dut_p (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .clear(clear),
      .count(count_p), .tc(tc_p), .wrap(wrap_p), .ovf(ovf_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic vec_t mk(int c, int l, int e, int u, int lv,
                               int cw, int ww, int ow, int tw,
                               int cs, int ws, int os, int ts);
      vec_t r;
      r.clr = c[0];  r.ld = l[0];  r.en = e[0];  r.ud = u[0];
      r.lv  = lv[3:0];
      r.cw  = cw[3:0]; r.ww = ww[0]; r.ow = ow[0]; r.tw = tw[0];
      r.cs  = cs[3:0]; r.ws = ws[0]; r.os = os[0]; r.ts = ts[0];
      return r;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b0;
      en       = 1'b0;
      up_dn    = 1'b0;
      load     = 1'b0;
      load_val = 4'd0;
      clear    = 1'b0;

      //        clr ld en ud lv | cw ww ow tw | cs ws os ts
      v[0]  = mk(1, 1, 1, 1, 5,   0, 0, 0, 0,   0, 0, 0, 0);
      v[1]  = mk(0, 0, 1, 1, 0,   1, 0, 0, 0,   1, 0, 0, 0);
      v[2]  = mk(0, 0, 1, 1, 0,   2, 0, 0, 0,   2, 0, 0, 0);
      v[3]  = mk(0, 0, 1, 1, 0,   3, 0, 0, 0,   3, 0, 0, 0);
      v[4]  = mk(0, 0, 1, 1, 0,   4, 0, 0, 0,   4, 0, 0, 0);
      v[5]  = mk(0, 0, 1, 1, 0,   5, 0, 0, 0,   5, 0, 0, 0);
      v[6]  = mk(0, 0, 1, 1, 0,   6, 0, 0, 0,   6, 0, 0, 0);
      v[7]  = mk(0, 0, 1, 1, 0,   7, 0, 0, 0,   7, 0, 0, 0);
      v[8]  = mk(0, 0, 1, 1, 0,   8, 0, 0, 0,   8, 0, 0, 0);
      v[9]  = mk(0, 0, 1, 1, 0,   9, 0, 0, 1,   9, 0, 0, 1);
      v[10] = mk(0, 0, 1, 1, 0,   0, 1, 1, 0,   9, 1, 1, 1);
      v[11] = mk(0, 0, 1, 1, 0,   1, 0, 1, 0,   9, 1, 1, 1);
      v[12] = mk(0, 0, 0, 1, 0,   1, 0, 1, 0,   9, 0, 1, 1);
      v[13] = mk(1, 0, 0, 1, 0,   0, 0, 0, 0,   0, 0, 0, 0);
      v[14] = mk(0, 1, 0, 0, 2,   2, 0, 0, 0,   2, 0, 0, 0);
      v[15] = mk(0, 0, 1, 0, 0,   1, 0, 0, 0,   1, 0, 0, 0);
      v[16] = mk(0, 0, 1, 0, 0,   0, 0, 0, 1,   0, 0, 0, 1);
      v[17] = mk(0, 0, 1, 0, 0,   9, 1, 1, 0,   0, 1, 1, 1);
      v[18] = mk(0, 0, 1, 0, 0,   8, 0, 1, 0,   0, 1, 1, 1);
      v[19] = mk(0, 1, 1, 1, 15,  9, 0, 1, 1,   9, 0, 1, 1);
      v[20] = mk(0, 1, 0, 1, 5,   5, 0, 1, 0,   5, 0, 1, 0);
      v[21] = mk(0, 0, 1, 1, 0,   6, 0, 1, 0,   6, 0, 1, 0);
      v[22] = mk(0, 0, 1, 0, 0,   5, 0, 1, 0,   5, 0, 1, 0);
      v[23] = mk(0, 0, 1, 1, 0,   6, 0, 1, 0,   6, 0, 1, 0);
      v[24] = mk(0, 0, 1, 0, 0,   5, 0, 1, 0,   5, 0, 1, 0);
      v[25] = mk(1, 0, 1, 0, 0,   0, 0, 0, 1,   0, 0, 0, 1);

      // reset state
      #12;
      chk("rst_count_w", 0, count_w, 4'd0);
      chk("rst_wrap_w", 0, {3'b0, wrap_w}, 4'd0);
      chk("rst_ovf_w", 0, {3'b0, ovf_w}, 4'd0);
      chk("rst_tc_w", 0, {3'b0, tc_w}, 4'd1);
      chk("rst_count_s", 0, count_s, 4'd0);
      @(negedge clk);
      rst = 1'b1;

      // table-driven vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         clear    = v[i].clr;
         load     = v[i].ld;
         en       = v[i].en;
         up_dn    = v[i].ud;
         load_val = v[i].lv;
         @(posedge clk);
         #1;
         chk("count_w", i, count_w, v[i].cw);
         chk("wrap_w", i, {3'b0, wrap_w}, {3'b0, v[i].ww});
         chk("ovf_w", i, {3'b0, ovf_w}, {3'b0, v[i].ow});
         chk("tc_w", i, {3'b0, tc_w}, {3'b0, v[i].tw});
         chk("count_s", i, count_s, v[i].cs);
         chk("wrap_s", i, {3'b0, wrap_s}, {3'b0, v[i].ws});
         chk("ovf_s", i, {3'b0, ovf_s}, {3'b0, v[i].os});
         chk("tc_s", i, {3'b0, tc_s}, {3'b0, v[i].ts});
      end

      // tc follows up_dn without a clock edge
      @(negedge clk);
      clear    = 1'b0;
      en       = 1'b0;
      load     = 1'b1;
      load_val = 4'd9;
      up_dn    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("tc_comb_up", 0, {3'b0, tc_w}, 4'd1);
      up_dn = 1'b0;
      #1;
      chk("tc_comb_dn", 0, {3'b0, tc_w}, 4'd0);

      // asynchronous reset in mid-cycle
      @(negedge clk);
      load     = 1'b1;
      load_val = 4'd0;
      @(negedge clk);
      load  = 1'b0;
      en    = 1'b1;
      up_dn = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b0;
      chk("pre_rst_count_w", 0, count_w, 4'd9);
      chk("pre_rst_ovf_w", 0, {3'b0, ovf_w}, 4'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count_w", 0, count_w, 4'd0);
      chk("async_rst_ovf_w", 0, {3'b0, ovf_w}, 4'd0);
      chk("async_rst_count_s", 0, count_s, 4'd0);
      @(negedge clk);
      rst = 1'b1;

      // prescaled instance: 9 enabled cycles separated by idle gaps
      up_dn = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         en = 1'b1;
         @(negedge clk);
         en = 1'b0;
         @(posedge clk);
         #1;
         if (k == 2) begin
`ifdef PRESCALER_EN
            chk("presc_mid", k, count_p, 4'd0);
`else
            chk("presc_mid", k, count_p, 4'd2);
`endif
         end
      end
`ifdef PRESCALER_EN
      chk("presc_end", 9, count_p, 4'd3);
`else
      chk("presc_end", 9, count_p, 4'd9);
`endif
      chk("presc_w_end", 9, count_w, 4'd9);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
